apb_cfg_bank: RTL and testbench

Parametrised APB3 configuration register bank for the accelerator. It generalises the fixed register map to NUM_REGS generic words, adds one-wait-state APB with PSLVERR on bad addresses, and provides a sticky done/interrupt status. An optional shadow bank lets the host program the next layer while the current one runs. It sits between the host APB bus and the TPU control/datapath, which consume the flattened cfg_q bus.

---
 rtl/cfg_pkg.sv | 19 +
 rtl/cfg_storage_bank.sv | 47 ++++
 rtl/apb_cfg_bank.sv | 190 +++++++++++++++++++
 tb/tb_apb_cfg_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared constants for apb_cfg_bank: control-word layout, APB FSM states and response codes.
package cfg_pkg;

    localparam int CTRL_IDX     = 0;
    localparam int START_BIT    = 0;
    localparam int PE_RESET_BIT = 15;
    localparam int IRQ_EN_BIT   = 30;
    localparam int DONE_BIT     = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RESP  = 2'd2
    } apb_state_e;

    localparam logic APB_RESP_OKAY = 1'b0;
    localparam logic APB_RESP_ERR  = 1'b1;

endpackage

// File: rtl/cfg_storage_bank.sv
// NUM_REGS x DATA_W register storage: single write port, whole-bank load, read mux, reset load.
module cfg_storage_bank #(
    parameter int                         NUM_REGS  = 32,
    parameter int                         DATA_W    = 32,
    parameter int                         IDX_W     = 5,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_en_i,
    input  logic [IDX_W-1:0]             wr_idx_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic                         ld_en_i,
    input  logic [NUM_REGS*DATA_W-1:0]   ld_data_i,
    input  logic [IDX_W-1:0]             rd_idx_i,
    output logic [DATA_W-1:0]            rd_data_o,
    output logic [NUM_REGS*DATA_W-1:0]   words_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    // Bank load has priority over a single-word write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
            end
        end else if (ld_en_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= ld_data_i[i*DATA_W +: DATA_W];
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

    // Flatten the array for the consumer bus.
    always_comb begin
        words_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            words_o[i*DATA_W +: DATA_W] = mem_q[i];
        end
    end

endmodule

// File: rtl/apb_cfg_bank.sv
// APB3 configuration register bank with one wait state, start/done control word and sticky irq.
// Build option CFG_SHADOW_EN: APB targets a staging bank that is copied to cfg_q on an accepted start.
module apb_cfg_bank
    import cfg_pkg::*;
#(
    parameter int                         NUM_REGS  = 32,
    parameter int                         DATA_W    = 32,
    parameter int                         ADDR_W    = 8,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic [DATA_W-1:0]            PWDATA,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_REGS*DATA_W-1:0]   cfg_q,
    output logic                         start_tpu,
    output logic                         pe_reset,
    output logic                         busy,
    output logic                         irq,
    input  logic                         done_tpu
);

    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int WIDX_W = ADDR_W - 2;
    localparam logic [WIDX_W:0]   NUM_REGS_W = (WIDX_W+1)'(NUM_REGS);
    localparam logic [DATA_W-1:0] CTRL_MASK  = (DATA_W'(1) << START_BIT) |
                                               (DATA_W'(1) << PE_RESET_BIT) |
                                               (DATA_W'(1) << DONE_BIT);

    // Host-visible form of the control word: pulse bits read 0, bit 31 is the sticky flag.
    function automatic logic [DATA_W-1:0] ctrl_view(input logic [DATA_W-1:0] w, input logic done);
        logic [DATA_W-1:0] v;
        v           = w & ~CTRL_MASK;
        v[DONE_BIT] = done;
        return v;
    endfunction

    apb_state_e                  state_q, state_d;
    logic [DATA_W-1:0]           prdata_q, prdata_d;
    logic                        pready_q, pslverr_q, pslverr_d;
    logic                        start_q, pe_q, busy_q, busy_d, done_q, done_d;
    logic                        irq_q, irq_d, irq_en_d, done_prev_q, done_rise_s;
    logic [WIDX_W-1:0]           word_idx_s;
    logic [IDX_W-1:0]            idx_s;
    logic                        is_ctrl_s, addr_err_s, err_s, acc_s, wr_ok_s;
    logic                        start_acc_s, pe_acc_s, w1c_s;
    logic [DATA_W-1:0]           wr_data_s, vis_rd_s, vis_word0_s, rd_view_s;
    logic [NUM_REGS*DATA_W-1:0]  act_words_s, vis_words_s;

    assign word_idx_s = PADDR[ADDR_W-1:2];
    assign idx_s      = word_idx_s[IDX_W-1:0];
    assign is_ctrl_s  = (word_idx_s == WIDX_W'(CTRL_IDX));
    assign addr_err_s = (PADDR[1:0] != 2'b00) || ({1'b0, word_idx_s} >= NUM_REGS_W);

    // APB phase tracking; the access happens on the SETUP->RESP transition.
    always_comb begin
        state_d = state_q;
        acc_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) state_d = SETUP;
                else                  state_d = IDLE;
            end
            SETUP: begin
                if (PSEL && PENABLE) begin
                    state_d = RESP;
                    acc_s   = 1'b1;
                end else if (!PSEL) begin
                    state_d = IDLE;
                end else begin
                    state_d = SETUP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access decode: a start request while busy rejects the whole write.
    always_comb begin
        err_s       = addr_err_s || (PWRITE && is_ctrl_s && PWDATA[START_BIT] && busy_q);
        wr_ok_s     = acc_s && PWRITE && !err_s;
        start_acc_s = wr_ok_s && is_ctrl_s && PWDATA[START_BIT];
        pe_acc_s    = wr_ok_s && is_ctrl_s && PWDATA[PE_RESET_BIT];
        w1c_s       = wr_ok_s && is_ctrl_s && PWDATA[DONE_BIT];
        if (is_ctrl_s) wr_data_s = PWDATA & ~CTRL_MASK;
        else           wr_data_s = PWDATA;
        if (is_ctrl_s) rd_view_s = ctrl_view(vis_rd_s, done_q);
        else           rd_view_s = vis_rd_s;
    end

`ifdef CFG_SHADOW_EN
    logic [NUM_REGS*DATA_W-1:0] stg_words_s, ld_data_s;
    logic [DATA_W-1:0]          act_rd_s;

    cfg_storage_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .IDX_W(IDX_W), .RESET_VAL(RESET_VAL)) u_stage (
        .clk_i(PCLK), .rst_i(PRESET), .wr_en_i(wr_ok_s), .wr_idx_i(idx_s), .wr_data_i(wr_data_s),
        .ld_en_i(1'b0), .ld_data_i('0), .rd_idx_i(idx_s), .rd_data_o(vis_rd_s), .words_o(stg_words_s)
    );

    // The start write lands in staging on the same edge, so the copy takes the new control word.
    always_comb begin
        ld_data_s = stg_words_s;
        ld_data_s[CTRL_IDX*DATA_W +: DATA_W] = wr_data_s;
    end

    cfg_storage_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .IDX_W(IDX_W), .RESET_VAL(RESET_VAL)) u_active (
        .clk_i(PCLK), .rst_i(PRESET), .wr_en_i(1'b0), .wr_idx_i(idx_s), .wr_data_i(wr_data_s),
        .ld_en_i(start_acc_s), .ld_data_i(ld_data_s), .rd_idx_i(idx_s), .rd_data_o(act_rd_s),
        .words_o(act_words_s)
    );

    assign vis_words_s = stg_words_s;
`else
    cfg_storage_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .IDX_W(IDX_W), .RESET_VAL(RESET_VAL)) u_bank (
        .clk_i(PCLK), .rst_i(PRESET), .wr_en_i(wr_ok_s), .wr_idx_i(idx_s), .wr_data_i(wr_data_s),
        .ld_en_i(1'b0), .ld_data_i('0), .rd_idx_i(idx_s), .rd_data_o(vis_rd_s), .words_o(act_words_s)
    );

    assign vis_words_s = act_words_s;
`endif

    assign vis_word0_s = vis_words_s[CTRL_IDX*DATA_W +: DATA_W];

    // Status next-state: a done edge wins over W1C/start for the sticky bit, start wins for busy.
    always_comb begin
        done_rise_s = done_tpu && !done_prev_q;
        if (start_acc_s)      busy_d = 1'b1;
        else if (done_rise_s) busy_d = 1'b0;
        else                  busy_d = busy_q;
        if (done_rise_s)                done_d = 1'b1;
        else if (start_acc_s || w1c_s)  done_d = 1'b0;
        else                            done_d = done_q;
        if (wr_ok_s && is_ctrl_s) irq_en_d = PWDATA[IRQ_EN_BIT];
        else                      irq_en_d = vis_word0_s[IRQ_EN_BIT];
        irq_d = done_d && irq_en_d;
        if (acc_s && !PWRITE && !err_s) prdata_d = rd_view_s;
        else                            prdata_d = '0;
        if (acc_s && err_s) pslverr_d = APB_RESP_ERR;
        else                pslverr_d = APB_RESP_OKAY;
    end

    // All control, status and response registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= APB_RESP_OKAY;
            start_q     <= 1'b0;
            pe_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prdata_q    <= prdata_d;
            pready_q    <= (state_d == RESP);
            pslverr_q   <= pslverr_d;
            start_q     <= start_acc_s;
            pe_q        <= pe_acc_s;
            busy_q      <= busy_d;
            done_q      <= done_d;
            irq_q       <= irq_d;
            done_prev_q <= done_tpu;
        end
    end

    // Active bank as seen by the datapath, control word in its host-visible form.
    always_comb begin
        cfg_q = act_words_s;
        cfg_q[CTRL_IDX*DATA_W +: DATA_W] = ctrl_view(act_words_s[CTRL_IDX*DATA_W +: DATA_W], done_q);
    end

    assign PRDATA    = prdata_q;
    assign PREADY    = pready_q;
    assign PSLVERR   = pslverr_q;
    assign start_tpu = start_q;
    assign pe_reset  = pe_q;
    assign busy      = busy_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_apb_cfg_bank.sv
// Self-checking bench for apb_cfg_bank: directed scenarios then random APB traffic against a register-map model.
module tb_apb_cfg_bank;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 8;
    localparam logic [NUM_REGS*DATA_W-1:0] RST_VAL = (NUM_REGS*DATA_W)'(32'h0000_0008) << (3*DATA_W);

    logic                       PCLK = 1'b0;
    logic                       PRESET, PSEL, PENABLE, PWRITE, done_tpu;
    logic [ADDR_W-1:0]          PADDR;
    logic [DATA_W-1:0]          PWDATA, PRDATA;
    logic                       PREADY, PSLVERR, start_tpu, pe_reset, busy, irq;
    logic [NUM_REGS*DATA_W-1:0] cfg_q;

    int n_checks = 0;
    int n_errors = 0;

    // Register-map model: staging (host view) and active (cfg_q) words plus status flags.
    logic [31:0] m_stg [NUM_REGS];
    logic [31:0] m_act [NUM_REGS];
    logic        m_done, m_busy;
    logic [31:0] last_rd;
    logic        last_err;

    apb_cfg_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_VAL(RST_VAL)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .cfg_q(cfg_q), .start_tpu(start_tpu), .pe_reset(pe_reset), .busy(busy), .irq(irq),
        .done_tpu(done_tpu)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] view0(input logic [31:0] w);
        logic [31:0] v;
        v     = w;
        v[0]  = 1'b0;
        v[15] = 1'b0;
        v[31] = m_done;
        return v;
    endfunction

    function automatic logic [31:0] exp_cfg(input int w);
        if (w == 0) return view0(m_act[0]);
        return m_act[w];
    endfunction

    function automatic logic [31:0] cfg_word(input int w);
        return cfg_q[w*DATA_W +: DATA_W];
    endfunction

    // One full APB transfer (setup, access, response) with model update at the access edge.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
        int          idx;
        logic        err, exp_start, exp_pe;
        logic [31:0] exp_rd;
        idx       = int'(addr[7:2]);
        err       = (addr[1:0] != 2'b00) || (idx >= NUM_REGS) || (wr && idx == 0 && wdata[0] && m_busy);
        exp_rd    = 32'h0;
        exp_start = 1'b0;
        exp_pe    = 1'b0;
        if (!err && !wr) exp_rd = (idx == 0) ? view0(m_stg[0]) : m_stg[idx];

        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(negedge PCLK);
        chk_eq("pready_t0", {31'b0, PREADY}, 32'h0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        chk_eq("pready_t1", {31'b0, PREADY}, 32'h0);
        @(posedge PCLK);
        if (!err && wr) begin
            m_stg[idx] = wdata;
            if (idx == 0) begin
                exp_start = wdata[0];
                exp_pe    = wdata[15];
                if (wdata[31]) m_done = 1'b0;
                if (wdata[0]) begin
                    m_busy = 1'b1;
                    m_done = 1'b0;
`ifdef CFG_SHADOW_EN
                    for (int i = 0; i < NUM_REGS; i++) m_act[i] = m_stg[i];
`endif
                end
            end
`ifndef CFG_SHADOW_EN
            m_act[idx] = wdata;
`endif
        end
        @(negedge PCLK);
        chk_eq("pready_t2", {31'b0, PREADY}, 32'h1);
        chk_eq("prdata", PRDATA, exp_rd);
        chk_eq("pslverr", {31'b0, PSLVERR}, {31'b0, err});
        chk_eq("start_t2", {31'b0, start_tpu}, {31'b0, exp_start});
        chk_eq("pe_reset_t2", {31'b0, pe_reset}, {31'b0, exp_pe});
        chk_eq("busy", {31'b0, busy}, {31'b0, m_busy});
        chk_eq("irq", {31'b0, irq}, {31'b0, m_done & m_stg[0][30]});
        chk_eq("cfg_word", cfg_word(idx % NUM_REGS), exp_cfg(idx % NUM_REGS));
        chk_eq("cfg_word0", cfg_word(0), exp_cfg(0));
        last_rd  = PRDATA;
        last_err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk_eq("idle_resp", {28'b0, PREADY, PSLVERR, start_tpu, pe_reset}, 32'h0);
        chk_eq("idle_prdata", PRDATA, 32'h0);
    endtask

    // Rising edge on done_tpu; status must hold for one cycle then update.
    task automatic done_pulse();
        @(posedge PCLK); #1;
        done_tpu = 1'b1;
        @(negedge PCLK);
        chk_eq("busy_before_done", {31'b0, busy}, {31'b0, m_busy});
        @(posedge PCLK);
        m_busy = 1'b0;
        m_done = 1'b1;
        @(negedge PCLK);
        chk_eq("busy_after_done", {31'b0, busy}, 32'h0);
        chk_eq("irq_after_done", {31'b0, irq}, {31'b0, m_stg[0][30]});
        chk_eq("cfg0_after_done", cfg_word(0), exp_cfg(0));
        @(posedge PCLK); #1;
        done_tpu = 1'b0;
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        int          r;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h00; PWDATA = 32'h0; done_tpu = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            m_stg[i] = RST_VAL[i*DATA_W +: DATA_W];
            m_act[i] = RST_VAL[i*DATA_W +: DATA_W];
        end
        m_done = 1'b0;
        m_busy = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        chk_eq("rst_outs", {25'b0, PREADY, PSLVERR, start_tpu, pe_reset, busy, irq, 1'b0}, 32'h0);
        chk_eq("rst_prdata", PRDATA, 32'h0);
        chk_eq("rst_cfg3", cfg_word(3), 32'h0000_0008);

        xfer(1'b0, 8'h0C, 32'h0);
        chk_eq("rd_w3_reset", last_rd, 32'h0000_0008);
        xfer(1'b1, 8'h0C, 32'h1234_5678);
        chk_eq("cfg3_written", cfg_word(3), 32'h1234_5678);
        xfer(1'b0, 8'h0C, 32'h0);
        chk_eq("rd_w3_back", last_rd, 32'h1234_5678);

        xfer(1'b1, 8'h80, 32'hDEAD_BEEF);
        chk_eq("err_oor", {31'b0, last_err}, 32'h1);
        xfer(1'b1, 8'h05, 32'hCAFE_F00D);
        chk_eq("err_misaligned", {31'b0, last_err}, 32'h1);
        xfer(1'b0, 8'h80, 32'h0);
        chk_eq("rd_oor_data", last_rd, 32'h0);
        xfer(1'b0, 8'h04, 32'h0);

        xfer(1'b1, 8'h00, 32'h4000_0001);
        chk_eq("busy_after_start", {31'b0, busy}, 32'h1);
        xfer(1'b1, 8'h00, 32'h0000_0001);
        chk_eq("err_start_busy", {31'b0, last_err}, 32'h1);
        done_pulse();
        chk_eq("irq_set", {31'b0, irq}, 32'h1);
        xfer(1'b0, 8'h00, 32'h0);
        chk_eq("rd_done_bit", {31'b0, last_rd[31]}, 32'h1);
        xfer(1'b1, 8'h00, 32'h8000_0000);
        chk_eq("irq_cleared", {31'b0, irq}, 32'h0);

        xfer(1'b1, 8'h00, 32'h0000_8000);
        xfer(1'b0, 8'h00, 32'h0);
        chk_eq("rd_pe_bit", {31'b0, last_rd[15]}, 32'h0);

        xfer(1'b1, 8'h00, 32'h0000_0001);
        xfer(1'b1, 8'h14, 32'h0000_00AA);
        done_pulse();
        xfer(1'b1, 8'h00, 32'h0000_0001);
        chk_eq("cfg5_after_start", cfg_word(5), 32'h0000_00AA);
        done_pulse();

        // Setup phase abandoned by the master: no access may take place.
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'h5555_AAAA;
        @(posedge PCLK); #1;
        PSEL = 1'b0;
        repeat (2) @(negedge PCLK);
        chk_eq("abort_pready", {31'b0, PREADY}, 32'h0);
        xfer(1'b0, 8'h10, 32'h0);

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 63))} | 8'h01;
            else if (r == 1) a = {2'b10, 6'($urandom_range(0, 15)), 2'b00} | 8'h80;
            else if (r < 4)  a = 8'h00;
            else             a = {1'b0, 5'($urandom_range(0, 31)), 2'b00};
            d = $urandom;
            xfer(1'($urandom_range(0, 1)), a, d);
            if ($urandom_range(0, 6) == 0) done_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
